// File: rtl/imem_loader.sv
// Streaming IMEM loader: frames of [N_lo, N_hi, 4*N payload bytes, xor checksum] are written
// word by word into instruction memory; the core is held in reset until a frame verifies.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_rst,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {StHdrLo, StHdrHi, StData, StCsum, StDone, StErr} state_e;

    localparam logic [16:0] Capacity = 17'(1) << ADDR_WIDTH;

    state_e                  state_q, state_d;
    logic [15:0]             n_q, n_d;
    logic [16:0]             word_idx_q, word_idx_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [31:0]             shift_q, shift_d;
    logic [7:0]              csum_q, csum_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;

    logic        accept;
    logic [16:0] hdr_n;
    logic        last_word;

    assign accept    = in_valid && in_ready;
    assign hdr_n     = {1'b0, in_data, n_q[7:0]};
    assign last_word = (word_idx_q + 17'd1) == {1'b0, n_q};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHdrLo;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHdrLo: if (accept) state_d = StHdrHi;
            StHdrHi: begin
                if (accept) begin
                    if (hdr_n > Capacity) state_d = StErr;
                    else if (hdr_n == 17'd0) state_d = StCsum;
                    else state_d = StData;
                end
            end
            StData: if (accept && byte_idx_q == 2'd3 && last_word) state_d = StCsum;
            StCsum: if (accept) state_d = (in_data == csum_q) ? StDone : StErr;
            StDone, StErr: if (restart) state_d = StHdrLo;
            default: state_d = StHdrLo;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = !rst && (state_q == StHdrLo || state_q == StHdrHi ||
                            state_q == StData  || state_q == StCsum);
        done     = (state_q == StDone);
        error    = (state_q == StErr);
        core_rst = (state_q != StDone);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q        <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        n_d        = n_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        unique case (state_q)
            StHdrLo: if (accept) n_d[7:0] = in_data;
            StHdrHi: begin
                if (accept) begin
                    n_d[15:8]  = in_data;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    csum_d     = '0;
                end
            end
            StData: begin
                if (accept) begin
                    shift_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    csum_d     = csum_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = word_idx_q[ADDR_WIDTH-1:0];
                        wdata_d    = shift_d;
                        word_idx_d = word_idx_q + 17'd1;
                    end
                end
            end
            StDone, StErr: begin
                if (restart) begin
                    csum_d     = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule
